// File: rtl/core_db_enc.sv
// Data-bucket Hamming(7,4) encoder: bucket word {data,hdr} -> 11-bit router packet {c[6:0],hdr}.
// Latency: one cycle from input transfer to out_data when the buffer is empty.
// Backpressure: FIFO_DEPTH-entry output buffer; in_ready drops only when full. Optional: CORE_DB_ENC_FAULT_INJECT_EN.

module core_db_fifo #(
    parameter int W     = 11,
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         push_vld,
    output logic         push_rdy,
    input  logic [W-1:0] push_dat,
    output logic         pop_vld,
    input  logic         pop_rdy,
    output logic [W-1:0] pop_dat,
    output logic         full
);
    // DEPTH must be a power of two so the pointers wrap for free.
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [CW-1:0] ONE_CNT  = CW'(1);

    typedef enum logic [1:0] {ST_EMPTY, ST_PARTIAL, ST_FULL} st_t;

    st_t           state;
    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count, count_nxt;
    logic          rdy_q, vld_q, full_q;
    logic          push, pop;

    assign push     = push_vld & rdy_q;
    assign pop      = vld_q & pop_rdy;
    assign push_rdy = rdy_q;
    assign pop_vld  = vld_q;
    assign full     = full_q;
    assign pop_dat  = vld_q ? mem[rd_ptr] : '0;

    always_comb begin
        count_nxt = count;
        if (push && !pop)
            count_nxt = count + 1'b1;
        else if (!push && pop)
            count_nxt = count - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= push_dat;
    end

    // rdy_q resets low so nothing is accepted until the first edge after release.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= ST_EMPTY;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            rdy_q  <= 1'b0;
            vld_q  <= 1'b0;
            full_q <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            count  <= count_nxt;
            rdy_q  <= (count_nxt != FULL_CNT);
            vld_q  <= (count_nxt != '0);
            full_q <= (count_nxt == FULL_CNT);
            case (state)
                ST_EMPTY:   if (push) state <= ST_PARTIAL;
                ST_PARTIAL: begin
                    if (push && !pop && count_nxt == FULL_CNT)
                        state <= ST_FULL;
                    else if (pop && !push && count == ONE_CNT)
                        state <= ST_EMPTY;
                end
                ST_FULL:    if (pop) state <= ST_PARTIAL;
                default:    state <= ST_EMPTY;
            endcase
        end
    end
endmodule

module core_db_enc #(
    parameter int FIFO_DEPTH = 2,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [10:0]      out_data,
    output logic [CNT_W-1:0] pkt_count,
    output logic             fifo_full
`ifdef CORE_DB_ENC_FAULT_INJECT_EN
    ,
    input  logic             inj_arm,
    input  logic [2:0]       inj_pos,
    output logic             inj_done
`endif
);
    typedef struct packed {
        logic [6:0] cw;
        logic [3:0] hdr;
    } pkt_t;

    logic [3:0]  d;
    logic [6:0]  cw_clean, flip;
    pkt_t        enc_pkt;
    logic [10:0] head_dat;

    assign d = in_data[7:4];
    // Bit k-1 holds Hamming position k: {d3,d2,d1,p4,d0,p2,p1}.
    assign cw_clean = {d[3], d[2], d[1], d[1] ^ d[2] ^ d[3],
                       d[0], d[0] ^ d[2] ^ d[3], d[0] ^ d[1] ^ d[3]};

`ifdef CORE_DB_ENC_FAULT_INJECT_EN
    logic       armed;
    logic [2:0] arm_pos;
    logic       in_xfer;

    assign in_xfer  = in_valid & in_ready;
    assign flip     = armed ? (7'd1 << (arm_pos - 3'd1)) : 7'd0;
    assign inj_done = armed & in_xfer;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            armed   <= 1'b0;
            arm_pos <= 3'd0;
        end else if (inj_arm && inj_pos != 3'd0) begin
            armed   <= 1'b1;
            arm_pos <= inj_pos;
        end else if (in_xfer) begin
            armed   <= 1'b0;
        end
    end
`else
    assign flip = 7'd0;
`endif

    assign enc_pkt = '{cw: cw_clean ^ flip, hdr: in_data[3:0]};

    core_db_fifo #(.W(11), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk      (clk),
        .reset_n  (reset_n),
        .push_vld (in_valid),
        .push_rdy (in_ready),
        .push_dat (enc_pkt),
        .pop_vld  (out_valid),
        .pop_rdy  (out_ready),
        .pop_dat  (head_dat),
        .full     (fifo_full)
    );

    assign out_data = head_dat;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            pkt_count <= '0;
        else if (out_valid && out_ready)
            pkt_count <= pkt_count + 1'b1;
    end
endmodule

// File: tb/tb_core_db_enc.sv
// Self-checking bench for core_db_enc: directed vectors, corner sequences and a queue-model random run.
module tb_core_db_enc;
    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_data;
    logic        out_valid;
    logic        out_ready;
    logic [10:0] out_data;
    logic [15:0] pkt_count;
    logic        fifo_full;
`ifdef CORE_DB_ENC_FAULT_INJECT_EN
    logic        inj_arm;
    logic [2:0]  inj_pos;
    logic        inj_done;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    core_db_enc #(.FIFO_DEPTH(DEPTH), .CNT_W(16)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .pkt_count (pkt_count),
        .fifo_full (fifo_full)
`ifdef CORE_DB_ENC_FAULT_INJECT_EN
        ,
        .inj_arm   (inj_arm),
        .inj_pos   (inj_pos),
        .inj_done  (inj_done)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference Hamming(7,4): place data at positions 3,5,6,7 and derive each parity
    // position 2^i as the XOR of every other position whose index has bit i set.
    function automatic logic [10:0] ref_enc(input logic [7:0] w);
        logic [7:0] pos;
        int dp;
        pos = '0;
        for (int i = 0; i < 4; i++) begin
            dp = (i == 0) ? 3 : (i == 1) ? 5 : (i == 2) ? 6 : 7;
            pos[dp] = w[4 + i];
        end
        for (int k = 1; k <= 4; k = k * 2) begin
            logic par;
            par = 1'b0;
            for (int j = 1; j <= 7; j++)
                if ((j & k) != 0 && j != k) par ^= pos[j];
            pos[k] = par;
        end
        return {pos[7:1], w[3:0]};
    endfunction

    typedef struct {
        logic [7:0]  din;
        logic [10:0] dout;
    } vec_t;

    vec_t        vecs[7];
    logic [10:0] q[$];
    logic [15:0] m_cnt;
    logic        m_push, m_pop;

    initial begin
        vecs[0] = '{8'h5A, 11'h2DA};
        vecs[1] = '{8'hF3, 11'h7F3};
        vecs[2] = '{8'h00, 11'h000};
        vecs[3] = '{8'h1C, 11'h07C};
        vecs[4] = '{8'h8F, 11'h4BF};
        vecs[5] = '{8'h25, 11'h195};
        vecs[6] = '{8'h40, 11'h2A0};

        reset_n   = 1'b0;
        in_valid  = 1'b0;
        in_data   = 8'hxx;
        out_ready = 1'b0;
`ifdef CORE_DB_ENC_FAULT_INJECT_EN
        inj_arm   = 1'b0;
        inj_pos   = 3'd0;
`endif
        #2;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready",  in_ready, 0);
        chk("rst_out_data",  out_data, 0);
        chk("rst_pkt_count", pkt_count, 0);
        chk("rst_fifo_full", fifo_full, 0);
        tick();
        tick();
        reset_n = 1'b1;
        #1;
        chk("rdy_before_edge", in_ready, 0);
        tick();
        chk("rdy_after_edge", in_ready, 1);

        // single word, one-cycle latency
        in_valid = 1'b1; in_data = 8'h5A; out_ready = 1'b1;
        tick();
        in_valid = 1'b0; in_data = 8'hxx;
        chk("t1_valid", out_valid, 1);
        chk("t1_data", out_data, 11'h2DA);
        tick();
        chk("t1_pkt", pkt_count, 1);
        chk("t1_empty", out_valid, 0);

        // back-to-back
        in_valid = 1'b1; in_data = 8'h00;
        tick();
        in_data = 8'hF3;
        chk("b2b_d0", out_data, 11'h000);
        chk("b2b_rdy0", in_ready, 1);
        tick();
        in_valid = 1'b0; in_data = 8'hxx;
        chk("b2b_d1", out_data, 11'h7F3);
        chk("b2b_rdy1", in_ready, 1);
        tick();
        chk("b2b_pkt", pkt_count, 3);

        // fill, stall, drain
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 8'h5A;
        tick();
        in_data = 8'hF3;
        tick();
        chk("full_flag", fifo_full, 1);
        chk("full_rdy", in_ready, 0);
        chk("full_head", out_data, 11'h2DA);
        in_data = 8'h00;
        tick();
        chk("stall_head", out_data, 11'h2DA);
        chk("stall_full", fifo_full, 1);
        out_ready = 1'b1;
        tick();
        chk("drain0", out_data, 11'h7F3);
        tick();
        in_valid = 1'b0; in_data = 8'hxx;
        chk("drain1", out_data, 11'h000);
        tick();
        chk("drain_empty", out_valid, 0);
        chk("drain_pkt", pkt_count, 6);

        // push and pop together at count 1
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 8'h5A;
        tick();
        in_data = 8'hF3; out_ready = 1'b1;
        tick();
        in_valid = 1'b0; in_data = 8'hxx;
        chk("pp_valid", out_valid, 1);
        chk("pp_data", out_data, 11'h7F3);
        chk("pp_full", fifo_full, 0);
        chk("pp_pkt", pkt_count, 7);
        tick();
        chk("pp_pkt2", pkt_count, 8);
        chk("pp_empty", out_valid, 0);

        // asynchronous reset with two words buffered
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 8'h5A;
        tick();
        in_data = 8'hF3;
        tick();
        in_valid = 1'b0; in_data = 8'hxx;
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst_valid", out_valid, 0);
        chk("arst_pkt", pkt_count, 0);
        chk("arst_rdy", in_ready, 0);
        chk("arst_full", fifo_full, 0);
        chk("arst_data", out_data, 0);
        tick();
        reset_n = 1'b1;
        tick();
        chk("post_rst_empty", out_valid, 0);
        in_valid = 1'b1; in_data = 8'hF3; out_ready = 1'b1;
        tick();
        in_valid = 1'b0; in_data = 8'hxx;
        chk("post_rst_data", out_data, 11'h7F3);
        tick();

        // vector table
        for (int i = 0; i < 7; i++) begin
            in_valid = 1'b1; in_data = vecs[i].din;
            tick();
            in_valid = 1'b0; in_data = 8'hxx;
            chk($sformatf("vec%0d", i), out_data, 32'(vecs[i].dout));
            tick();
        end

`ifdef CORE_DB_ENC_FAULT_INJECT_EN
        inj_arm = 1'b1; inj_pos = 3'd3;
        tick();
        inj_arm = 1'b0; inj_pos = 3'd0;
        in_valid = 1'b1; in_data = 8'h5A;
        #1;
        chk("inj_done_hi", inj_done, 1);
        tick();
        chk("inj_data", out_data, 11'h29A);
        chk("inj_done_lo", inj_done, 0);
        tick();
        in_valid = 1'b0; in_data = 8'hxx;
        chk("inj_clean", out_data, 11'h2DA);
        tick();
`endif

        // randomized run against the queue model
        reset_n = 1'b0;
        #1;
        reset_n = 1'b1;
        tick();
        m_cnt = '0;
        q.delete();
        for (int c = 0; c < 3000; c++) begin
            in_valid  = ($urandom_range(0, 2) != 0);
            in_data   = in_valid ? 8'($urandom) : 8'hxx;
            out_ready = ($urandom_range(0, 3) != 0);
            #1;
            chk("rnd_rdy",   in_ready, (q.size() < DEPTH));
            chk("rnd_valid", out_valid, (q.size() > 0));
            chk("rnd_data",  out_data, (q.size() > 0) ? 32'(q[0]) : 32'd0);
            chk("rnd_full",  fifo_full, (q.size() == DEPTH));
            chk("rnd_pkt",   pkt_count, m_cnt);
            m_push = in_valid && (q.size() < DEPTH);
            m_pop  = out_ready && (q.size() > 0);
            @(posedge clk);
            if (m_pop) begin
                void'(q.pop_front());
                m_cnt = m_cnt + 16'd1;
            end
            if (m_push)
                q.push_back(ref_enc(in_data));
            #1;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
